cycle_print_engine: RTL

- Parametrised successor to the arbitrage-cycle printer.
- Scans vertex memory port B for entries whose cycle flag is set and walks each predecessor chain until it returns to the start vertex.
- Renders the cycle as decimal vertex numbers separated by arrows into the character frame buffer, and clears the flag of every vertex it visits.
- Adds a start/busy/done handshake, arbitrary digit count, a hop-limit guard, optional newline per cycle, and a found-cycle counter.

---
 rtl/cycle_print_pkg.sv | 41 ++++
 rtl/bin2bcd_serial.sv | 52 +++++
 rtl/cycle_print_engine.sv | 264 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/cycle_print_pkg.sv
// Shared types, glyph codes and vertex-entry field helpers for the cycle print engine.
package cycle_print_pkg;

    localparam int unsigned SPACE_CHAR  = 10;
    localparam int unsigned ARROW_CHAR  = 37;
    localparam int unsigned MAX_ENTRY_W = 64;

    typedef logic [MAX_ENTRY_W-1:0] entry_raw_t;

    typedef enum logic [3:0] {
        IDLE,
        SCAN_RD,
        SCAN_CHK,
        HOP_RD,
        HOP_CLR,
        CONV,
        EMIT,
        ARROW,
        SEP,
        DONE
    } state_t;

    // Entries are zero-extended to MAX_ENTRY_W so one helper serves any field widths.
    function automatic logic entry_flag(entry_raw_t e, int unsigned entry_w);
        return 1'(e >> (entry_w - 1));
    endfunction

    function automatic logic [15:0] entry_pred(entry_raw_t e, int unsigned weight_w,
                                               int unsigned pred_w);
        entry_raw_t mask;
        mask = (MAX_ENTRY_W'(1) << pred_w) - MAX_ENTRY_W'(1);
        return 16'((e >> weight_w) & mask);
    endfunction

    function automatic logic [31:0] entry_weight(entry_raw_t e, int unsigned weight_w);
        entry_raw_t mask;
        mask = (MAX_ENTRY_W'(1) << weight_w) - MAX_ENTRY_W'(1);
        return 32'(e & mask);
    endfunction

endpackage

// File: rtl/bin2bcd_serial.sv
// Serial shift-add-3 binary to BCD converter; done pulses BIN_W+1 cycles after start.
module bin2bcd_serial #(
    parameter int unsigned BIN_W  = 6,
    parameter int unsigned DIGITS = 2
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  start,
    input  logic [BIN_W-1:0]      bin,
    output logic                  done,
    output logic [4*DIGITS-1:0]   bcd
);

    localparam int unsigned CNT_W = $clog2(BIN_W + 1);
    localparam int unsigned BCD_W = 4 * DIGITS;

    logic [BIN_W-1:0] sr;
    logic [CNT_W-1:0] cnt;
    logic [BCD_W-1:0] adj_c;

    // Add 3 to every nibble of 5 or more before the next shift.
    always_comb begin
        adj_c = bcd;
        for (int unsigned d = 0; d < DIGITS; d++) begin
            if (bcd[4*d +: 4] >= 4'd5) begin
                adj_c[4*d +: 4] = bcd[4*d +: 4] + 4'd3;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sr   <= '0;
            cnt  <= '0;
            bcd  <= '0;
            done <= 1'b0;
        end else begin
            done <= 1'b0;
            if (start) begin
                sr  <= bin;
                bcd <= '0;
                cnt <= CNT_W'(BIN_W);
            end else if (cnt != '0) begin
                bcd  <= {adj_c[BCD_W-2:0], sr[BIN_W-1]};
                sr   <= {sr[BIN_W-2:0], 1'b0};
                cnt  <= cnt - CNT_W'(1);
                done <= (cnt == CNT_W'(1));
            end
        end
    end

endmodule

// File: rtl/cycle_print_engine.sv
// Finds flagged vertices, walks each predecessor chain back to its start and prints
// the cycle as decimal vertex numbers joined by arrows into the character frame.
module cycle_print_engine #(
    parameter int unsigned NODES      = 64,
    parameter int unsigned PRED_W     = 6,
    parameter int unsigned WEIGHT_W   = 16,
    parameter int unsigned DIGITS     = 2,
    parameter int unsigned COLS       = 40,
    parameter int unsigned ROWS       = 30,
    parameter int unsigned MAX_HOPS   = NODES,
    parameter int unsigned NEWLINE    = 1,
    parameter int unsigned SPACE_CHAR = cycle_print_pkg::SPACE_CHAR,
    parameter int unsigned ARROW_CHAR = cycle_print_pkg::ARROW_CHAR,
    localparam int unsigned ENTRY_W   = 1 + PRED_W + WEIGHT_W
) (
    input  logic               clk,
    input  logic               print_reset_n,
    input  logic               start,
    output logic               busy,
    output logic               done,
    input  logic [ENTRY_W-1:0] vertmat_q_b,
    output logic [PRED_W-1:0]  vertmat_addr_b,
    output logic [ENTRY_W-1:0] vertmat_data_b,
    output logic               vertmat_we_b,
    output logic [5:0]         frame_char,
    output logic [5:0]         frame_x,
    output logic [5:0]         frame_y,
    output logic               frame_we,
    output logic [PRED_W:0]    cycles_found,
    output logic               overflow
);

    import cycle_print_pkg::*;

    localparam int unsigned HOPS_W = $clog2(MAX_HOPS + 1);
    localparam int unsigned DIG_W  = $clog2(DIGITS + 1);

    state_t              state, state_nxt;
    logic [PRED_W-1:0]   j, j_nxt, s, s_nxt, v, v_nxt, p, p_nxt, addr_nxt;
    logic [HOPS_W-1:0]   hops, hops_nxt;
    logic [DIG_W-1:0]    dig, dig_nxt;
    logic                lz, lz_nxt;
    logic [ENTRY_W-1:0]  wdata_nxt;
    logic                vwe_nxt, fwe_nxt, conv_start, conv_start_nxt, conv_done;
    logic [5:0]          fchar_nxt, fx_nxt, fy_nxt, cx, cx_nxt, cy, cy_nxt;
    logic [PRED_W:0]     cf_nxt;
    logic                ov_nxt, busy_nxt, done_nxt;
    logic [4*DIGITS-1:0] bcd;
    logic [3:0]          digit_c;
    logic                emit_c;
    logic [5:0]          char_c;
    entry_raw_t          q_raw;

    assign q_raw   = MAX_ENTRY_W'(vertmat_q_b);
    assign digit_c = bcd[4*(DIGITS - 1 - int'(dig)) +: 4];

    bin2bcd_serial #(
        .BIN_W  (PRED_W),
        .DIGITS (DIGITS)
    ) u_bcd (
        .clk   (clk),
        .rst_n (print_reset_n),
        .start (conv_start),
        .bin   (v),
        .done  (conv_done),
        .bcd   (bcd)
    );

    always_comb begin
        state_nxt      = state;
        j_nxt          = j;
        s_nxt          = s;
        v_nxt          = v;
        p_nxt          = p;
        hops_nxt       = hops;
        dig_nxt        = dig;
        lz_nxt         = lz;
        addr_nxt       = vertmat_addr_b;
        wdata_nxt      = vertmat_data_b;
        vwe_nxt        = 1'b0;
        fwe_nxt        = 1'b0;
        conv_start_nxt = 1'b0;
        fchar_nxt      = frame_char;
        fx_nxt         = cx;
        fy_nxt         = cy;
        cx_nxt         = cx;
        cy_nxt         = cy;
        cf_nxt         = cycles_found;
        ov_nxt         = overflow;
        busy_nxt       = busy;
        done_nxt       = done;
        emit_c         = 1'b0;
        char_c         = 6'(SPACE_CHAR);

        case (state)
            IDLE, DONE: begin
                if (start) begin
                    j_nxt     = '0;
                    addr_nxt  = '0;
                    cf_nxt    = '0;
                    ov_nxt    = 1'b0;
                    busy_nxt  = 1'b1;
                    done_nxt  = 1'b0;
                    state_nxt = SCAN_RD;
                end
            end
            SCAN_RD: state_nxt = SCAN_CHK;
            SCAN_CHK: begin
                if (entry_flag(q_raw, ENTRY_W)) begin
                    s_nxt     = j;
                    v_nxt     = j;
                    hops_nxt  = '0;
                    state_nxt = HOP_CLR;
                end else if (j == PRED_W'(NODES - 1)) begin
                    busy_nxt  = 1'b0;
                    done_nxt  = 1'b1;
                    state_nxt = DONE;
                end else begin
                    j_nxt     = j + PRED_W'(1);
                    addr_nxt  = j + PRED_W'(1);
                    state_nxt = SCAN_RD;
                end
            end
            HOP_RD: begin
                if (v == s) begin
                    conv_start_nxt = 1'b1;
                    state_nxt      = CONV;
                end else begin
                    state_nxt = HOP_CLR;
                end
            end
            HOP_CLR: begin
                vwe_nxt        = 1'b1;
                wdata_nxt      = {1'b0, vertmat_q_b[ENTRY_W-2:0]};
                p_nxt          = PRED_W'(entry_pred(q_raw, WEIGHT_W, PRED_W));
                conv_start_nxt = 1'b1;
                state_nxt      = CONV;
            end
            CONV: begin
                if (conv_done) begin
                    dig_nxt   = '0;
                    lz_nxt    = 1'b1;
                    state_nxt = EMIT;
                end
            end
            EMIT: begin
                emit_c = 1'b1;
                if (lz && digit_c == 4'd0 && dig != DIG_W'(DIGITS - 1)) begin
                    char_c = 6'(SPACE_CHAR);
                end else begin
                    char_c = 6'(digit_c);
                    lz_nxt = 1'b0;
                end
                if (dig == DIG_W'(DIGITS - 1)) begin
                    if (v == s && hops != '0) begin
                        if (cycles_found != '1) begin
                            cf_nxt = cycles_found + (PRED_W+1)'(1);
                        end
                        state_nxt = SEP;
                    end else begin
                        state_nxt = ARROW;
                    end
                end else begin
                    dig_nxt = dig + DIG_W'(1);
                end
            end
            ARROW: begin
                emit_c   = 1'b1;
                char_c   = 6'(ARROW_CHAR);
                hops_nxt = hops + HOPS_W'(1);
                if (hops == HOPS_W'(MAX_HOPS - 1)) begin
                    ov_nxt    = 1'b1;
                    state_nxt = SEP;
                end else begin
                    v_nxt     = p;
                    addr_nxt  = p;
                    state_nxt = HOP_RD;
                end
            end
            SEP: begin
                if (NEWLINE != 0) begin
                    cx_nxt = '0;
                    cy_nxt = (cy == 6'(ROWS - 1)) ? 6'd0 : cy + 6'd1;
                end else begin
                    emit_c = 1'b1;
                    char_c = 6'(SPACE_CHAR);
                end
                if (j == PRED_W'(NODES - 1)) begin
                    busy_nxt  = 1'b0;
                    done_nxt  = 1'b1;
                    state_nxt = DONE;
                end else begin
                    j_nxt     = j + PRED_W'(1);
                    addr_nxt  = j + PRED_W'(1);
                    state_nxt = SCAN_RD;
                end
            end
            default: state_nxt = IDLE;
        endcase

        // The character lands at the current cursor, which then steps with wrap.
        if (emit_c) begin
            fwe_nxt   = 1'b1;
            fchar_nxt = char_c;
            if (cx == 6'(COLS - 1)) begin
                cx_nxt = '0;
                cy_nxt = (cy == 6'(ROWS - 1)) ? 6'd0 : cy + 6'd1;
            end else begin
                cx_nxt = cx + 6'd1;
            end
        end
    end

    always_ff @(posedge clk or negedge print_reset_n) begin
        if (!print_reset_n) begin
            state          <= IDLE;
            j              <= '0;
            s              <= '0;
            v              <= '0;
            p              <= '0;
            hops           <= '0;
            dig            <= '0;
            lz             <= 1'b0;
            vertmat_addr_b <= '0;
            vertmat_data_b <= '0;
            vertmat_we_b   <= 1'b0;
            frame_char     <= '0;
            frame_x        <= '0;
            frame_y        <= '0;
            frame_we       <= 1'b0;
            cx             <= '0;
            cy             <= '0;
            cycles_found   <= '0;
            overflow       <= 1'b0;
            busy           <= 1'b0;
            done           <= 1'b0;
            conv_start     <= 1'b0;
        end else begin
            state          <= state_nxt;
            j              <= j_nxt;
            s              <= s_nxt;
            v              <= v_nxt;
            p              <= p_nxt;
            hops           <= hops_nxt;
            dig            <= dig_nxt;
            lz             <= lz_nxt;
            vertmat_addr_b <= addr_nxt;
            vertmat_data_b <= wdata_nxt;
            vertmat_we_b   <= vwe_nxt;
            frame_char     <= fchar_nxt;
            frame_x        <= fx_nxt;
            frame_y        <= fy_nxt;
            frame_we       <= fwe_nxt;
            cx             <= cx_nxt;
            cy             <= cy_nxt;
            cycles_found   <= cf_nxt;
            overflow       <= ov_nxt;
            busy           <= busy_nxt;
            done           <= done_nxt;
            conv_start     <= conv_start_nxt;
        end
    end

endmodule
